// File: rtl/gsim_band_solver.sv
// Gauss-Seidel solver for a symmetric banded Toeplitz system (20, -13, 6, -1).
// Serial b load, in-place sweeps with optional early stop, ready/valid x stream.
module gsim_band_solver #(
  parameter int          N          = 16,
  parameter int          BW         = 16,
  parameter int          FRAC       = 16,
  parameter int          MAX_ITER   = 120,
  parameter int          EARLY_STOP = 1,
  parameter int          TOL        = 0,
  parameter logic [31:0] RECIP      = 32'h0CCCCCCD,
  parameter int          RSH        = 32,
  localparam int         XW         = BW + FRAC,
  localparam int         IW         = $clog2(N),
  localparam int         CW         = $clog2(MAX_ITER + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_en,
  input  logic signed [BW-1:0] b_in,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [XW-1:0] x_out,
  output logic                 out_last,
  output logic [CW-1:0]        iter_cnt
);

  localparam int ACW = XW + 6;
  localparam int PW  = ACW + 33;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_OUT} state_t;

  state_t                r_state, w_next;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_iter;
  logic                  r_conv;
  logic signed [XW-1:0]  r_x [N];
  logic signed [BW-1:0]  r_b [N];

  logic                  w_last_idx, w_load_acc;
  logic signed [XW-1:0]  w_xm [1:3];
  logic signed [XW-1:0]  w_xp [1:3];
  logic signed [ACW-1:0] w_s1, w_s2, w_s3, w_acc_iter, w_acc, w_delta;
  logic signed [PW-1:0]  w_prod, w_shift;
  logic                  w_ovf, w_elem_ok, w_sweep_ok, w_done;
  logic signed [XW-1:0]  w_x_new;
  logic [CW-1:0]         w_iter_inc;

  assign w_last_idx = (r_idx == IW'(N - 1));
  assign w_load_acc = in_en & ((r_state == S_IDLE) | (r_state == S_LOAD));

  // NOTE: every comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    for (int d = 1; d <= 3; d++) begin
      w_xm[d] = '0;
      w_xp[d] = '0;
      if (r_idx >= IW'(d))       w_xm[d] = r_x[r_idx - IW'(d)];
      if (r_idx <= IW'(N-1-d))   w_xp[d] = r_x[r_idx + IW'(d)];
    end
  end

  assign w_s1 = ACW'(w_xm[1]) + ACW'(w_xp[1]);
  assign w_s2 = ACW'(w_xm[2]) + ACW'(w_xp[2]);
  assign w_s3 = ACW'(w_xm[3]) + ACW'(w_xp[3]);
  assign w_acc_iter = (ACW'(r_b[r_idx]) <<< FRAC)
                    + ((w_s1 <<< 3) + (w_s1 <<< 2) + w_s1)
                    - ((w_s2 <<< 2) + (w_s2 <<< 1))
                    + w_s3;

  // One reciprocal multiplier serves both the load seed and the sweep update.
  assign w_acc   = (r_state == S_ITER) ? w_acc_iter : (ACW'(b_in) <<< FRAC);
  assign w_prod  = PW'(w_acc) * PW'($signed({1'b0, RECIP}));
  assign w_shift = w_prod >>> RSH;
  assign w_ovf   = ~(&w_shift[PW-1:XW-1]) & (|w_shift[PW-1:XW-1]);
  assign w_x_new = w_ovf ? (w_shift[PW-1] ? {1'b1, {(XW-1){1'b0}}} : {1'b0, {(XW-1){1'b1}}})
                         : w_shift[XW-1:0];

  assign w_delta    = ACW'(w_x_new) - ACW'(r_x[r_idx]);
  assign w_elem_ok  = (w_delta <= ACW'(TOL)) && (w_delta >= -ACW'(TOL));
  assign w_sweep_ok = w_elem_ok & ((r_idx == '0) | r_conv);
  assign w_iter_inc = r_iter + CW'(1);
  assign w_done     = (w_iter_inc == CW'(MAX_ITER)) | ((EARLY_STOP != 0) & w_sweep_ok);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_en)                   w_next = S_LOAD;
      S_LOAD: if (in_en && w_last_idx)     w_next = S_ITER;
      S_ITER: if (w_last_idx && w_done)    w_next = S_OUT;
      S_OUT:  if (out_ready && w_last_idx) w_next = S_IDLE;
      default:                             w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) | (r_state == S_LOAD);
    busy      = (r_state == S_ITER) | (r_state == S_OUT);
    out_valid = (r_state == S_OUT);
    out_last  = (r_state == S_OUT) & w_last_idx;
    x_out     = (r_state == S_OUT) ? r_x[r_idx] : '0;
    iter_cnt  = r_iter;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_iter <= '0;
      r_conv <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_en) begin
          r_idx  <= IW'(1);
          r_iter <= '0;
        end
        S_LOAD: if (in_en) r_idx <= w_last_idx ? '0 : r_idx + IW'(1);
        S_ITER: begin
          r_idx  <= w_last_idx ? '0 : r_idx + IW'(1);
          r_conv <= w_sweep_ok;
          if (w_last_idx) r_iter <= w_iter_inc;
        end
        S_OUT:  if (out_ready) r_idx <= w_last_idx ? '0 : r_idx + IW'(1);
        default: r_idx <= '0;
      endcase
    end
  end

  // NOTE: the x and b arrays carry no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (w_load_acc) begin
      r_x[r_idx] <= w_x_new;
      r_b[r_idx] <= b_in;
    end else if (r_state == S_ITER) begin
      r_x[r_idx] <= w_x_new;
    end
  end

endmodule
